// File: rtl/csm_pkg.sv
// csm_pkg: shared types and constants for the CSM shared register memory.
// Error codes, lock owners, port states, request ops and the access check.
package csm_pkg;

    localparam int NUM_REGS = 4;
    localparam int DATA_W   = 8;
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_RANGE   = 2'b01,
        ERR_LOCKED  = 2'b10,
        ERR_ILLEGAL = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        FREE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } owner_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } port_state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_READ,
        OP_WSTART,
        OP_WRITE,
        OP_HOLD,
        OP_RELEASE,
        OP_ILLEGAL
    } op_t;

    function automatic logic in_range(
        input logic [DATA_W-1:0] addr
    );
        return addr < DATA_W'(NUM_REGS);
    endfunction

    // Range check first, then lock check against the pre-edge owner.
    function automatic err_t access_err(
        input op_t               op,
        input logic [DATA_W-1:0] addr,
        input owner_t            own,
        input owner_t            self
    );
        err_t e;
        e = ERR_OK;
        if (op == OP_READ || op == OP_WRITE ||
            op == OP_HOLD) begin
            if (!in_range(addr))
                e = ERR_RANGE;
            else if (own != FREE && own != self)
                e = ERR_LOCKED;
        end else if (op == OP_RELEASE) begin
            if (!in_range(addr))
                e = ERR_RANGE;
            else if (own != self)
                e = ERR_ILLEGAL;
        end
        return e;
    endfunction

endpackage

// File: rtl/csm_shared_mem_if.sv
// csm_shared_mem_if: host-side strobes and responses for ports A and B.
// The host drives the master side; the shared memory is the slave.
interface csm_shared_mem_if;
    import csm_pkg::*;

    logic [DATA_W-1:0] A_in_AD;
    logic              A_rw;
    logic              A_enable;
    logic              A_hold;
    logic              A_release;
    logic              A_ack;
    logic [1:0]        A_err;
    logic [DATA_W-1:0] A_out_data;

    logic [DATA_W-1:0] B_in_AD;
    logic              B_rw;
    logic              B_enable;
    logic              B_hold;
    logic              B_release;
    logic              B_ack;
    logic [1:0]        B_err;
    logic [DATA_W-1:0] B_out_data;

    modport master (
        output A_in_AD, A_rw, A_enable,
        output A_hold, A_release,
        input  A_ack, A_err, A_out_data,
        output B_in_AD, B_rw, B_enable,
        output B_hold, B_release,
        input  B_ack, B_err, B_out_data
    );

    modport slave (
        input  A_in_AD, A_rw, A_enable,
        input  A_hold, A_release,
        output A_ack, A_err, A_out_data,
        input  B_in_AD, B_rw, B_enable,
        input  B_hold, B_release,
        output B_ack, B_err, B_out_data
    );

endinterface

// File: rtl/csm_port_fsm.sv
// csm_port_fsm: per-port strobe decode, IDLE/WDATA sequencing and
// registered ack/err/out_data for one cycle after each command commits.
module csm_port_fsm
    import csm_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_AD,
    input  logic              rw,
    input  logic              enable,
    input  logic              hold,
    input  logic              rel,
    output op_t               req_op,
    output logic [DATA_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_data,
    input  err_t              rsp_err,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              ack,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] out_data
);

    port_state_t       state;
    logic [DATA_W-1:0] addr_q;
    logic              multi;
    logic              sel_rd;
    logic              sel_wr;
    logic              sel_hd;
    logic              sel_rl;
    logic              sel_none;

    // One-hot strobe classification; exactly one select is true.
    always_comb begin
        multi    = (enable & hold) | (enable & rel) |
                   (hold & rel);
        sel_rd   = enable & ~rw & ~multi;
        sel_wr   = enable & rw & ~multi;
        sel_hd   = hold & ~multi;
        sel_rl   = rel & ~multi;
        sel_none = ~(enable | hold | rel);
    end

    // Request for the coming edge; WDATA ignores strobes.
    always_comb begin
        req_op   = OP_NONE;
        req_addr = in_AD;
        req_data = in_AD;
        if (state == WDATA) begin
            req_op   = OP_WRITE;
            req_addr = addr_q;
        end else begin
            unique case (1'b1)
                multi:    req_op = OP_ILLEGAL;
                sel_rd:   req_op = OP_READ;
                sel_wr:   req_op = OP_WSTART;
                sel_hd:   req_op = OP_HOLD;
                sel_rl:   req_op = OP_RELEASE;
                sel_none: req_op = OP_NONE;
                default:  req_op = OP_NONE;
            endcase
        end
    end

    // Sequence the port and register a one-cycle response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            ack      <= 1'b0;
            err      <= ERR_OK;
            out_data <= '0;
        end else begin
            ack      <= 1'b0;
            err      <= ERR_OK;
            out_data <= '0;
            unique case (req_op)
                OP_WSTART: begin
                    state  <= WDATA;
                    addr_q <= in_AD;
                end
                OP_WRITE: begin
                    state <= IDLE;
                    ack   <= 1'b1;
                    err   <= rsp_err;
                end
                OP_READ: begin
                    ack <= 1'b1;
                    err <= rsp_err;
                    if (rsp_err == ERR_OK)
                        out_data <= rsp_data;
                end
                OP_HOLD, OP_RELEASE: begin
                    ack <= 1'b1;
                    err <= rsp_err;
                end
                OP_ILLEGAL: begin
                    ack <= 1'b1;
                    err <= ERR_ILLEGAL;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/csm_shared_mem.sv
// csm_shared_mem: two-port shared register file with per-register locks.
// Port A wins every same-edge conflict against port B.
module csm_shared_mem
    import csm_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    csm_shared_mem_if.slave bus
);

    logic [DATA_W-1:0] mem [NUM_REGS];
    owner_t            lock [NUM_REGS];

    op_t               a_op;
    op_t               b_op;
    logic [DATA_W-1:0] a_addr;
    logic [DATA_W-1:0] b_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [DATA_W-1:0] a_rdata;
    logic [DATA_W-1:0] b_rdata;
    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  b_idx;
    err_t              a_err;
    err_t              b_err;
    logic              a_wr;
    logic              b_wr;
    logic              a_hd;
    logic              b_hd;
    logic              a_rl;
    logic              b_rl;

    csm_port_fsm u_port_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_AD    (bus.A_in_AD),
        .rw       (bus.A_rw),
        .enable   (bus.A_enable),
        .hold     (bus.A_hold),
        .rel      (bus.A_release),
        .req_op   (a_op),
        .req_addr (a_addr),
        .req_data (a_data),
        .rsp_err  (a_err),
        .rsp_data (a_rdata),
        .ack      (bus.A_ack),
        .err      (bus.A_err),
        .out_data (bus.A_out_data)
    );

    csm_port_fsm u_port_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_AD    (bus.B_in_AD),
        .rw       (bus.B_rw),
        .enable   (bus.B_enable),
        .hold     (bus.B_hold),
        .rel      (bus.B_release),
        .req_op   (b_op),
        .req_addr (b_addr),
        .req_data (b_data),
        .rsp_err  (b_err),
        .rsp_data (b_rdata),
        .ack      (bus.B_ack),
        .err      (bus.B_err),
        .out_data (bus.B_out_data)
    );

    // Verdicts against pre-edge state; B loses same-register ties.
    always_comb begin
        a_idx   = a_addr[IDX_W-1:0];
        b_idx   = b_addr[IDX_W-1:0];
        a_rdata = mem[a_idx];
        b_rdata = mem[b_idx];
        a_err   = access_err(a_op, a_addr,
                             lock[a_idx], OWN_A);
        b_err   = access_err(b_op, b_addr,
                             lock[b_idx], OWN_B);
        a_wr = (a_op == OP_WRITE) && (a_err == ERR_OK);
        a_hd = (a_op == OP_HOLD) && (a_err == ERR_OK);
        a_rl = (a_op == OP_RELEASE) && (a_err == ERR_OK);
        if (b_err == ERR_OK && b_idx == a_idx) begin
            if ((b_op == OP_WRITE && a_wr) ||
                (b_op == OP_HOLD && a_hd))
                b_err = ERR_LOCKED;
        end
        b_wr = (b_op == OP_WRITE) && (b_err == ERR_OK);
        b_hd = (b_op == OP_HOLD) && (b_err == ERR_OK);
        b_rl = (b_op == OP_RELEASE) && (b_err == ERR_OK);
    end

    // Register file: commit accepted writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                mem[i] <= '0;
        end else begin
            if (a_wr)
                mem[a_idx] <= a_data;
            if (b_wr)
                mem[b_idx] <= b_data;
        end
    end

    // Lock table: commit accepted holds and releases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                lock[i] <= FREE;
        end else begin
            if (a_hd)
                lock[a_idx] <= OWN_A;
            if (a_rl)
                lock[a_idx] <= FREE;
            if (b_hd)
                lock[b_idx] <= OWN_B;
            if (b_rl)
                lock[b_idx] <= FREE;
        end
    end

endmodule

// File: doc/csm_shared_mem.md
# csm_shared_mem

Two-port shared register memory: the responder end of the CSM host protocol. Processors A and B each drive a multiplexed address/data byte bus with rw/enable/hold/release strobes. The block decodes each port's commands, arbitrates access to a small register file with per-register hold locks, and returns ack, error code and read data per port. It is the design under test for the CSM host-driver bench.

## Interface
- NUM_REGS, 4: number of 8-bit shared registers; valid addresses 0..NUM_REGS-1.
- DATA_W, 8: register and bus width.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- A_in_AD / B_in_AD  in  8  address in the command cycle, write data in the data cycle.
- A_rw / B_rw  in  1  1 = write, 0 = read; qualified by enable.
- A_enable / B_enable  in  1  read/write command strobe.
- A_hold / B_hold  in  1  lock the register at in_AD to this port.
- A_release / B_release  in  1  unlock the register at in_AD.
- A_ack / B_ack  out  1  one-cycle command-complete pulse.
- A_err / B_err  out  2  status, valid while ack=1, else 00.
- A_out_data / B_out_data  out  8  read data, valid while ack=1 on a successful read, else 00.

## Operation
- Error codes: 00 OK, 01 address >= NUM_REGS, 10 register locked by the other port or lost arbitration, 11 illegal command.
- Command decode in the port's IDLE state, sampled each rising edge. None of enable/hold/release set: no action, no ack. More than one set: ack with err 11, no action.
- Read: enable=1, rw=0. Register value is returned with ack.
- Write: enable=1, rw=1. Address is sampled in the command cycle. Data is sampled on the next edge (WDATA state); strobes are ignored in WDATA. Lock and range checks are applied at the commit edge.
- Hold: takes a free register, or re-holds an owned one (OK). Register held by the other port: err 10.
- Release: only the owner may release (OK). Releasing a free register or one owned by the other port: err 11.
- Lock table: one owner per register, with values FREE, A or B. Unlocked registers are open to both ports. A locked register rejects the other port's read, write and hold with err 10.
- Same-edge conflicts: A has fixed priority.
  - A and B commit writes to the same register: A's data is stored; B gets err 10.
  - A and B hold the same free register: A becomes owner; B gets err 10.
  - Read and write to the same register on the same edge: the read returns the pre-write value.
- Lock updates take effect after the edge on which they commit. An access committing on that same edge is checked against the previous lock state.
- Out-of-range checks take precedence over lock checks.

## Timing
- Reset (asynchronous): all registers 00, all locks FREE, both ports IDLE, ack=0, err=00, out_data=00. Reset asserted mid-write discards the write.
- Read, hold, release, illegal command: command sampled at edge T; ack/err/out_data registered at T and visible for exactly one cycle.
- Write: address at edge T (IDLE->WDATA), data at edge T+1 (WDATA->IDLE). Memory is updated at T+1, and ack is visible for one cycle after T+1.
- A port is back in IDLE during its ack cycle and may present its next command in that cycle. Strobes still asserted there are treated as a new command.
- Ports are independent: A in WDATA does not stall B.

## Structure
- Package csm_pkg:
  - err_t enum: ERR_OK, ERR_RANGE, ERR_LOCKED, ERR_ILLEGAL.
  - owner_t enum: FREE, OWN_A, OWN_B.
  - port_state_t enum: IDLE, WDATA.
  - NUM_REGS and DATA_W defaults.
- Sub-module csm_port_fsm, instantiated once per port:
  - Decodes strobes.
  - Sequences IDLE/WDATA.
  - Emits a one-cycle request (op, addr, data).
  - Registers the ack/err/out_data returned by the top.
- Top level holds the register file, lock table, range check and A-priority arbitration.

## Test plan
- Reset, then A write addr 2 data 8'hA5, then A read addr 2 -> write ack with err 00 one cycle after the data cycle; read ack with out_data A5, err 00.
- A hold addr 1; B write addr 1 data FF -> B ack err 10; A read addr 1 returns 00; A release addr 1 (err 00); B retries the write -> err 00.
- A and B write addr 3 with data 11 and 22, data cycles aligned -> A err 00, B err 10; subsequent read of addr 3 returns 11.
- A read addr 7 -> ack err 01, out_data 00. B hold=1 with enable=1 -> err 11. B release of free addr 0 -> err 11.
- A and B hold addr 0 on the same edge -> A err 00, B err 10. A re-hold of addr 0 -> err 00.
- Assert reset_n low during A's WDATA cycle with data 5A -> no ack, addr unchanged at 00, all locks FREE after reset.
